// File: rtl/l2_miss_sequencer.sv
// L2 miss/eviction sequencer: optional dirty-victim writeback, then line fill,
// or a write-no-allocate bypass. Drives the datapath mux selects and way
// update strobes, and keeps saturating miss/writeback counters.
module l2_miss_sequencer #(
  parameter int unsigned WAYS           = 8,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned OFFS_W         = 5,
  parameter int unsigned IDX_W          = 3,
  parameter int unsigned TAG_W          = ADDR_W - IDX_W - OFFS_W,
  parameter int unsigned WRITE_ALLOCATE = 1,
  parameter int unsigned CNT_W          = 16,
  localparam int unsigned WAY_W         = $clog2(WAYS),
  localparam int unsigned SEL_W         = $clog2(WAYS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_valid,
  input  logic [ADDR_W-1:0]     miss_addr,
  input  logic                  miss_write,
  input  logic [WAY_W-1:0]      victim_way,
  input  logic [WAYS-1:0]       way_valid,
  input  logic [WAYS-1:0]       way_dirty,
  input  logic [WAYS*TAG_W-1:0] way_tags,
  input  logic                  pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_W-1:0]     pmem_addr,
  output logic [SEL_W-1:0]      pmem_addr_sel,
  output logic                  data_in_sel,
  output logic [WAYS-1:0]       data_write_en,
  output logic                  tag_load,
  output logic                  valid_set,
  output logic                  dirty_clr,
  output logic [WAY_W-1:0]      fill_way,
  output logic                  busy,
  output logic                  miss_done,
  output logic [CNT_W-1:0]      miss_cnt,
  output logic [CNT_W-1:0]      wb_cnt
);

  typedef enum logic [2:0] {StIdle, StWb, StFill, StBypass, StDone} state_e;

  localparam logic [ADDR_W-1:0] LineMask = {{(ADDR_W - OFFS_W){1'b1}}, {OFFS_W{1'b0}}};

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [WAY_W-1:0]   way_q;
  logic [TAG_W-1:0]   tag_q;
  logic [CNT_W-1:0]   miss_cnt_q, wb_cnt_q;
  logic               accept, wb_inc;

  // State register, accept-time capture of the transaction, saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      way_q      <= '0;
      tag_q      <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= miss_addr;
        way_q  <= victim_way;
        tag_q  <= way_tags[int'(victim_way)*TAG_W +: TAG_W];
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
      if (wb_inc && (wb_cnt_q != '1)) wb_cnt_q <= wb_cnt_q + CNT_W'(1);
    end
  end

  // Next-state decode and all datapath controls; outputs are pure functions of
  // state and pmem_resp so an async reset drops any pmem request at once.
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    wb_inc        = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr     = '0;
    pmem_addr_sel = '0;
    data_in_sel   = 1'b0;
    data_write_en = '0;
    tag_load      = 1'b0;
    valid_set     = 1'b0;
    dirty_clr     = 1'b0;
    fill_way      = '0;
    miss_done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        data_in_sel = 1'b1;
        if (miss_valid) begin
          accept = 1'b1;
          if (miss_write && (WRITE_ALLOCATE == 0)) begin
            state_d = StBypass;
          end else if (way_valid[victim_way] && way_dirty[victim_way]) begin
            state_d = StWb;
          end else begin
            state_d = StFill;
          end
        end
      end
      StWb: begin
        pmem_write    = 1'b1;
        pmem_addr     = {tag_q, addr_q[OFFS_W +: IDX_W], {OFFS_W{1'b0}}};
        pmem_addr_sel = SEL_W'(way_q) + SEL_W'(1);
        data_in_sel   = 1'b1;
        if (pmem_resp) begin
          dirty_clr = 1'b1;
          fill_way  = way_q;
          wb_inc    = 1'b1;
          state_d   = StFill;
        end
      end
      StFill: begin
        pmem_read = 1'b1;
        pmem_addr = addr_q & LineMask;
        if (pmem_resp) begin
          data_write_en = WAYS'(1) << way_q;
          tag_load      = 1'b1;
          valid_set     = 1'b1;
          fill_way      = way_q;
          state_d       = StDone;
        end
      end
      StBypass: begin
        pmem_write  = 1'b1;
        pmem_addr   = addr_q & LineMask;
        data_in_sel = 1'b1;
        if (pmem_resp) state_d = StDone;
      end
      StDone: begin
        data_in_sel = 1'b1;
        miss_done   = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;

endmodule
